// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared types and sizing helpers for the serial transmitter
//
// Purpose : state encoding, frame length and counter width used by serial_tx
//           and serial_tx_bitcnt.
// Macro   : SERIAL_TX_PARITY_EN - when defined, every frame carries one extra
//           even-parity bit after the data bits.
// Ports   : none (package).

package serial_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

`ifdef SERIAL_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Number of serial bits per frame for a given data width.
  function automatic int frame_len(input int width);
    return width + (PARITY_EN ? 1 : 0);
  endfunction

  // Counter must hold 0..FRAME without wrapping.
  function automatic int cnt_width(input int frame);
    return $clog2(frame + 1);
  endfunction

endpackage

// File: rtl/serial_tx_bitcnt.sv
// rtl/serial_tx_bitcnt.sv - enabled bit counter with clear and last-bit flag
//
// Purpose : counts consumed bits of a frame; last_o marks the final bit.
// Ports   : clk      - rising-edge clock
//           reset_n  - asynchronous active-low reset
//           clr_i    - synchronous clear to 0 (priority over en_i)
//           en_i     - advance the count by one
//           last_o   - count equals FRAME-1
// Macro   : SERIAL_TX_PARITY_EN (via serial_tx_pkg, affects FRAME only).

module serial_tx_bitcnt
  import serial_tx_pkg::*;
#(
  parameter int FRAME = 8,
  parameter int CW    = cnt_width(FRAME)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign last_o = (count_q == CW'(FRAME - 1));

  // Saturating at FRAME-1 keeps the count inside the frame even if the
  // caller keeps enabling without clearing.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !last_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - parallel-in serial-out transmitter with load handshake
//
// Purpose : accepts one WIDTH-bit word over load_valid/load_ready and emits
//           it one bit per ser_en-qualified clock, MSB or LSB first.
// Ports   : clk        - rising-edge clock
//           reset_n    - asynchronous active-low reset
//           load_valid - load_data is valid
//           load_ready - transmitter can accept a word
//           load_data  - word to transmit
//           ser_en     - bit strobe; current bit consumed when high in SHIFT
//           ser_out    - current serial bit (flop output)
//           ser_valid  - ser_out carries a frame bit
//           busy       - frame in progress
//           done       - one-cycle pulse after the last bit is consumed
// Macro   : SERIAL_TX_PARITY_EN - append an even-parity bit to each frame.

module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int FRAME = frame_len(WIDTH);

  tx_state_t        state_q;
  logic [FRAME-1:0] sreg_q;
  logic [FRAME-1:0] sreg_d;
  logic [FRAME-1:0] frame_img;
  logic             ser_valid_q;
  logic             load_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             cnt_last;
  logic             load_fire;
  logic             consume;
  logic             frame_end;

  assign load_fire = (state_q == IDLE) && load_valid;
  assign consume   = (state_q == SHIFT) && ser_en;
  assign frame_end = consume && cnt_last;

  // The word is laid out so the first bit to send sits at the output end;
  // the parity bit (if any) sits at the far end and arrives last.
`ifdef SERIAL_TX_PARITY_EN
  assign frame_img = MSB_FIRST ? {load_data, ^load_data} : {^load_data, load_data};
`else
  assign frame_img = load_data;
`endif

  // Shift toward the output end, back-filling with zeros.
  assign sreg_d = MSB_FIRST ? {sreg_q[FRAME-2:0], 1'b0} : {1'b0, sreg_q[FRAME-1:1]};

  // ser_out is taken straight from the output-end flop; the register is
  // cleared when the frame ends so ser_out reads 0 in IDLE.
  assign ser_out    = MSB_FIRST ? sreg_q[FRAME-1] : sreg_q[0];
  assign ser_valid  = ser_valid_q;
  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;

  serial_tx_bitcnt #(
    .FRAME (FRAME)
  ) u_bitcnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (load_fire | frame_end),
    .en_i    (consume),
    .last_o  (cnt_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      ser_valid_q  <= 1'b0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            state_q      <= SHIFT;
            sreg_q       <= frame_img;
            ser_valid_q  <= 1'b1;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        SHIFT: begin
          if (ser_en) begin
            if (cnt_last) begin
              state_q      <= IDLE;
              sreg_q       <= '0;
              ser_valid_q  <= 1'b0;
              load_ready_q <= 1'b1;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              sreg_q <= sreg_d;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - scoreboard bench for serial_tx (MSB-first and LSB-first instances)

module tb_serial_tx;

  logic       clk;
  logic       reset_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       ser_en;
  logic [1:0] load_ready;
  logic [1:0] ser_out;
  logic [1:0] ser_valid;
  logic [1:0] busy;
  logic [1:0] done;

  serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready[0]),
    .load_data  (load_data),
    .ser_en     (ser_en),
    .ser_out    (ser_out[0]),
    .ser_valid  (ser_valid[0]),
    .busy       (busy[0]),
    .done       (done[0])
  );

  serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready[1]),
    .load_data  (load_data),
    .ser_en     (ser_en),
    .ser_out    (ser_out[1]),
    .ser_valid  (ser_valid[1]),
    .busy       (busy[1]),
    .done       (done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected bit streams per instance, in transmit order.
  bit exp_m[$];
  bit exp_l[$];
  bit model_idle = 1'b1;
  bit done_exp   = 1'b0;
  int acc_cnt    = 0;
  int pop_cnt    = 0;
  int en_mode    = 0;

  task automatic chk(input string name, input int k, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%b expected=%b t=%0t", name, k, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout %s actual=expired expected=event t=%0t", name, $time);
  endtask

  task automatic push_frame(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      exp_m.push_back(d[7-i]);
      exp_l.push_back(d[i]);
    end
`ifdef SERIAL_TX_PARITY_EN
    exp_m.push_back(^d);
    exp_l.push_back(^d);
`endif
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      logic eb;
      eb = 1'b0;
      if (!model_idle) begin
        if (k == 0 && exp_m.size() > 0) eb = exp_m[0];
        if (k == 1 && exp_l.size() > 0) eb = exp_l[0];
      end
      chk("load_ready", k, load_ready[k], model_idle);
      chk("busy",       k, busy[k],       !model_idle);
      chk("ser_valid",  k, ser_valid[k],  !model_idle);
      chk("done",       k, done[k],       done_exp);
      chk("ser_out",    k, ser_out[k],    eb);
    end
  endtask

  // Monitor: compare at negedge, then advance the model for the next edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_m.delete();
      exp_l.delete();
      model_idle = 1'b1;
      done_exp   = 1'b0;
      check_outputs();
    end else begin
      bit next_done;
      check_outputs();
      next_done = 1'b0;
      if (model_idle) begin
        if (load_valid) begin
          push_frame(load_data);
          model_idle = 1'b0;
          acc_cnt++;
        end
      end else if (ser_en) begin
        void'(exp_m.pop_front());
        void'(exp_l.pop_front());
        pop_cnt++;
        if (exp_m.size() == 0) begin
          model_idle = 1'b1;
          next_done  = 1'b1;
        end
      end
      done_exp = next_done;
    end
  end

  // ser_en driver: 0 = held high, 1 = toggling, 2 = random.
  initial begin
    ser_en = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (en_mode)
        0:       ser_en = 1'b1;
        1:       ser_en = ~ser_en;
        default: ser_en = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send(input logic [7:0] d, input int mode, input bit hold);
    int start;
    bit got;
    en_mode    = mode;
    load_valid = 1'b1;
    load_data  = d;
    start      = acc_cnt;
    got        = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk);
      if (acc_cnt != start) got = 1'b1;
    end
    #2;
    if (!hold) load_valid = 1'b0;
    if (!got) fail_timeout("load accept");
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      if (model_idle && exp_m.size() == 0) ok = 1'b1;
    end
    if (!ok) fail_timeout("frame end");
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic check_reset_now();
    for (int k = 0; k < 2; k++) begin
      chk("async load_ready", k, load_ready[k], 1'b1);
      chk("async busy",       k, busy[k],       1'b0);
      chk("async ser_valid",  k, ser_valid[k],  1'b0);
      chk("async done",       k, done[k],       1'b0);
      chk("async ser_out",    k, ser_out[k],    1'b0);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Steady enable, then toggling enable.
    send(8'hA5, 0, 1'b0);
    wait_idle();
    send(8'h3C, 1, 1'b0);
    wait_idle();

    // Load held during SHIFT with new data: ignored until the done cycle.
    send(8'hFF, 0, 1'b1);
    load_data = 8'h00;
    begin
      int start;
      bit got;
      start = acc_cnt;
      got   = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(posedge clk);
        if (acc_cnt != start) got = 1'b1;
      end
      #2;
      load_valid = 1'b0;
      if (!got) fail_timeout("back-to-back accept");
    end
    wait_idle();

    // Reset mid-frame after three consumed bits.
    begin
      int start;
      send(8'h81, 0, 1'b0);
      start = pop_cnt;
      for (int i = 0; i < 100 && (pop_cnt - start) < 3; i++) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_now();
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #2;
    end
    send(8'h42, 0, 1'b0);
    wait_idle();

    // Parity-sensitive words with random stalls.
    send(8'hA5, 2, 1'b0);
    wait_idle();
    send(8'h07, 2, 1'b0);
    wait_idle();

    // Random words, some back-to-back.
    for (int n = 0; n < 20; n++) begin
      send(8'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    load_valid = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
